// File: rtl/sensor_hub_pkg.sv
// Shared register map, controller state encoding and reset data for the sensor hub.
package sensor_hub_pkg;

    localparam int unsigned REG_ENB    = 32'h200;
    localparam int unsigned REG_CLEAR  = 32'h201;
    localparam int unsigned REG_STATUS = 32'h202;
    localparam int unsigned REG_MASK   = 32'h203;
    localparam int unsigned REG_CSEL   = 32'h204;
    localparam int unsigned REG_COUNT  = 32'h205;

    // COUNT_SEL holds a channel index for up to 8 channels
    localparam int SEL_W = 3;

    localparam int IDLE_B  = 0;
    localparam int READ_B  = 1;
    localparam int WRITE_B = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_READ  = 3'b010,
        S_WRITE = 3'b100
    } state_t;

    localparam logic [31:0] EMPTY_DATA = 32'h0;

endpackage

// File: rtl/sensor_chan_buf.sv
// One sensor channel: linear (non-wrapping) sample buffer with fill count, full flag
// and an asynchronous read port for the CPU side.
module sensor_chan_buf
    import sensor_hub_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_enb,
    input  logic                       i_clear,
    input  logic                       i_s_valid,
    input  logic [DATA_W-1:0]          i_s_data,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
    output logic                       o_s_ready,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [DATA_W-1:0]          o_rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic [AW-1:0]     w_wptr;
    logic              w_cap;

    // Without wrap the write pointer is simply the fill count below DEPTH
    assign w_wptr    = r_count[AW-1:0];
    assign o_s_ready = i_enb & ~r_full;
    assign w_cap     = i_s_valid & o_s_ready & ~i_clear;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= DATA_W'(EMPTY_DATA);
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (w_cap) begin
            r_mem[w_wptr] <= i_s_data;
            r_count       <= r_count + 1'b1;
            r_full        <= (r_count == CW'(DEPTH - 1));
        end
    end

    assign o_full    = r_full;
    assign o_count   = r_count;
    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/sensor_hub_ctrl.sv
// Multi-channel sensor hub: word-addressed slave port over NUM_CH capture buffers,
// with enable / clear / irq-mask registers and a level interrupt on any unmasked full buffer.
module sensor_hub_ctrl
    import sensor_hub_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic                     o_ready,
    output logic                     o_rvalid,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_wack,
    input  logic [NUM_CH-1:0]        i_s_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_s_data,
    output logic [NUM_CH-1:0]        o_s_ready,
    output logic                     o_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [ADDR_W-1:0] A_ENB    = ADDR_W'(REG_ENB);
    localparam logic [ADDR_W-1:0] A_CLEAR  = ADDR_W'(REG_CLEAR);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(REG_MASK);
    localparam logic [ADDR_W-1:0] A_CSEL   = ADDR_W'(REG_CSEL);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(REG_COUNT);
    localparam logic [ADDR_W-1:0] A_BUFEND = ADDR_W'(NUM_CH * DEPTH);

    state_t                        r_state, w_next;
    logic [ADDR_W-1:0]             r_addr;
    logic [DATA_W-1:0]             r_wdata, r_rdata;
    logic [NUM_CH-1:0]             r_enb, r_mask, w_clear, w_full;
    logic [SEL_W-1:0]              r_sel;
    logic [NUM_CH-1:0][DATA_W-1:0] w_buf_rd;
    logic [NUM_CH-1:0][CW-1:0]     w_count;
    logic [DATA_W-1:0]             w_rd_mux, w_sel_count;
    logic                          w_accept, w_unused;

    assign o_ready  = r_state[IDLE_B];
    assign o_rvalid = r_state[READ_B];
    assign o_wack   = r_state[WRITE_B];
    assign o_rdata  = r_rdata;
    assign o_irq    = |(w_full & r_mask);
    assign w_accept = i_req & o_ready;
    assign w_clear  = (r_state == S_WRITE && r_addr == A_CLEAR) ? r_wdata[NUM_CH-1:0] : '0;
    assign w_unused = ^r_wdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_req) w_next = i_we ? S_WRITE : S_READ;
            S_READ:  w_next = S_IDLE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_count = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (r_sel == SEL_W'(c)) w_sel_count = DATA_W'(w_count[c]);
    end

    // Read data is sampled at accept, so it reflects the state as of that cycle
    always_comb begin
        w_rd_mux = DATA_W'(EMPTY_DATA);
        if (i_addr < A_BUFEND) begin
            for (int c = 0; c < NUM_CH; c++)
                if (i_addr[ADDR_W-1:AW] == (ADDR_W-AW)'(c)) w_rd_mux = w_buf_rd[c];
        end else begin
            case (i_addr)
                A_ENB:    w_rd_mux = DATA_W'(r_enb);
                A_STATUS: w_rd_mux = DATA_W'(w_full);
                A_MASK:   w_rd_mux = DATA_W'(r_mask);
                A_CSEL:   w_rd_mux = DATA_W'(r_sel);
                A_COUNT:  w_rd_mux = w_sel_count;
                default:  w_rd_mux = DATA_W'(EMPTY_DATA);
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_enb   <= '0;
            r_mask  <= '0;
            r_sel   <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                if (!i_we) r_rdata <= w_rd_mux;
            end
            if (r_state == S_WRITE) begin
                case (r_addr)
                    A_ENB:   r_enb  <= r_wdata[NUM_CH-1:0];
                    A_MASK:  r_mask <= r_wdata[NUM_CH-1:0];
                    A_CSEL:  r_sel  <= r_wdata[SEL_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sensor_chan_buf #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_buf (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_enb     (r_enb[c]),
            .i_clear   (w_clear[c]),
            .i_s_valid (i_s_valid[c]),
            .i_s_data  (i_s_data[c*DATA_W +: DATA_W]),
            .i_rd_idx  (i_addr[AW-1:0]),
            .o_s_ready (o_s_ready[c]),
            .o_full    (w_full[c]),
            .o_count   (w_count[c]),
            .o_rd_data (w_buf_rd[c])
        );
    end

endmodule

// File: tb/tb_sensor_hub_ctrl.sv
// Directed bench for sensor_hub_ctrl: bus reads are scored against a queue of expected words.
module tb_sensor_hub_ctrl;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 64;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     req = 1'b0;
    logic                     we = 1'b0;
    logic [ADDR_W-1:0]        addr = '0;
    logic [DATA_W-1:0]        wdata = '0;
    logic [NUM_CH-1:0]        s_valid = '0;
    logic [NUM_CH*DATA_W-1:0] s_data = '0;
    logic                     o_ready, o_rvalid, o_wack, o_irq;
    logic [DATA_W-1:0]        o_rdata;
    logic [NUM_CH-1:0]        o_s_ready;

    int          n_tot = 0;
    int          n_pass = 0;
    logic [31:0] q_exp[$];
    string       q_tag[$];

    sensor_hub_ctrl #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_we      (we),
        .i_addr    (addr),
        .i_wdata   (wdata),
        .o_ready   (o_ready),
        .o_rvalid  (o_rvalid),
        .o_rdata   (o_rdata),
        .o_wack    (o_wack),
        .i_s_valid (s_valid),
        .i_s_data  (s_data),
        .o_s_ready (o_s_ready),
        .o_irq     (o_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot = n_tot + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string tag);
        int          n;
        logic [31:0] ex;
        string       t;
        q_exp.push_back(e);
        q_tag.push_back(tag);
        @(negedge clk);
        n = 0;
        while (!o_ready && n < 8) begin @(negedge clk); n++; end
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        n = 0;
        while (!o_rvalid && n < 4) begin @(negedge clk); n++; end
        ex = q_exp.pop_front();
        t  = q_tag.pop_front();
        chk({t, "_rvalid"}, 32'(o_rvalid), 32'd1);
        chk({t, "_lat"}, 32'(n), 32'd0);
        if (o_rvalid) chk(t, o_rdata, ex);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input string tag,
                      input logic [NUM_CH-1:0] sv = '0, input logic [31:0] sd = '0);
        int n;
        @(negedge clk);
        n = 0;
        while (!o_ready && n < 8) begin @(negedge clk); n++; end
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1 req = 1'b0; we = 1'b0;
        // optional strobes land in the WRITE cycle itself
        s_valid = sv;
        for (int c = 0; c < NUM_CH; c++) if (sv[c]) s_data[c*DATA_W +: DATA_W] = sd;
        @(negedge clk);
        chk({tag, "_wack"}, 32'(o_wack), 32'd1);
        @(posedge clk); #1 s_valid = '0;
    endtask

    task automatic push(input int ch, input logic [31:0] d);
        @(negedge clk);
        s_valid[ch] = 1'b1;
        s_data[ch*DATA_W +: DATA_W] = d;
        @(posedge clk); #1 s_valid[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_rvalid", 32'(o_rvalid), 32'd0);
        chk("rst_wack", 32'(o_wack), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_irq", 32'(o_irq), 32'd0);
        chk("rst_sready", 32'(o_s_ready), 32'd0);
        rst = 1'b0;

        rd(10'h202, 32'h0, "status0");
        rd(10'h203, 32'h0, "mask0");
        rd(10'h200, 32'h0, "enb0");

        // fill ch0 to capacity
        wr(10'h200, 32'h1, "enb_ch0");
        chk("sready_ch0", 32'(o_s_ready), 32'h1);
        for (int i = 0; i < DEPTH; i++) push(0, 32'h100 + i);
        @(negedge clk);
        chk("sready_full", 32'(o_s_ready), 32'h0);
        chk("irq_masked", 32'(o_irq), 32'd0);
        rd(10'h202, 32'h1, "status_full");
        rd(10'h03F, 32'h13F, "buf_last");
        wr(10'h204, 32'h0, "sel0");
        rd(10'h205, 32'd64, "count_full");
        push(0, 32'hDEAD);
        rd(10'h205, 32'd64, "count_drop");

        wr(10'h203, 32'h1, "mask_ch0");
        @(negedge clk);
        chk("irq_set", 32'(o_irq), 32'd1);
        wr(10'h201, 32'h1, "clear_ch0");
        @(negedge clk);
        chk("irq_clr", 32'(o_irq), 32'd0);
        rd(10'h205, 32'd0, "count_clr");
        rd(10'h000, 32'h100, "buf_keep");
        rd(10'h201, 32'h0, "clear_rd");
        chk("sready_resume", 32'(o_s_ready), 32'h1);

        // CLEAR racing a capture on ch1
        wr(10'h200, 32'h2, "enb_ch1");
        for (int i = 0; i < 5; i++) push(1, 32'h200 + i);
        wr(10'h204, 32'h1, "sel1");
        rd(10'h205, 32'd5, "count_ch1");
        wr(10'h201, 32'h2, "clear_race", 4'b0010, 32'hBEEF);
        rd(10'h205, 32'd0, "count_race");
        rd(10'h045, 32'h0, "race_notstored");
        rd(10'h040, 32'h200, "race_keep0");

        // old ENB governs a capture in the same cycle as the ENB write
        wr(10'h200, 32'h0, "enb_race", 4'b0010, 32'h0BEE);
        rd(10'h205, 32'd1, "count_enbrace");
        rd(10'h040, 32'h0BEE, "buf_enbrace");
        chk("sready_off", 32'(o_s_ready), 32'h0);

        wr(10'h204, 32'h2, "sel2");
        for (int i = 0; i < 10; i++) push(2, 32'h500 + i);
        rd(10'h205, 32'd0, "count_dis");
        rd(10'h3FF, 32'h0, "unmapped_rd");
        wr(10'h3FF, 32'hFFFF_FFFF, "unmapped_wr");
        rd(10'h200, 32'h0, "enb_after_unm");
        rd(10'h204, 32'h2, "sel_after_unm");
        rd(10'h203, 32'h1, "mask_after_unm");

        // disable mid-fill then resume at the held pointer
        wr(10'h200, 32'h8, "enb_ch3");
        for (int i = 0; i < 3; i++) push(3, 32'h300 + i);
        wr(10'h200, 32'h0, "dis_ch3");
        push(3, 32'h3AA);
        push(3, 32'h3AB);
        wr(10'h200, 32'h8, "reen_ch3");
        push(3, 32'h303);
        wr(10'h204, 32'h3, "sel3");
        rd(10'h205, 32'd4, "count_resume");
        rd(10'h0C3, 32'h303, "buf_resume");

        // reset while a read is in flight
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 10'h200;
        @(posedge clk); #1 req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstmid_rvalid", 32'(o_rvalid), 32'd0);
        chk("rstmid_ready", 32'(o_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        chk("rstmid_irq", 32'(o_irq), 32'd0);
        chk("rstmid_sready", 32'(o_s_ready), 32'h0);
        rd(10'h200, 32'h0, "rstmid_enb");
        rd(10'h203, 32'h0, "rstmid_mask");
        rd(10'h204, 32'h0, "rstmid_sel");
        rd(10'h205, 32'h0, "rstmid_count");
        rd(10'h0C0, 32'h0, "rstmid_buf");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
